// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow controller.
// High-score logic is enabled by defining GAME_CTRL_HISCORE_EN.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    OVER = 2'd3
  } game_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [15:0] SCORE_MAX_BCD = 16'h9999;

endpackage

// File: rtl/game_ctrl_if.sv
// Player/timer-facing signal bundle of game_ctrl.
// master drives the inputs, slave is the controller.
interface game_ctrl_if;
  import game_pkg::*;

  logic        start_btn;
  logic        hit;
  logic        game_over;
  logic        timer_reset;
  logic        running;
  game_state_t state;
  logic [15:0] score_bcd;
  logic [15:0] hi_bcd;
  logic        new_hi;

  modport master (
    output start_btn, hit, game_over,
    input  timer_reset, running, state,
    input  score_bcd, hi_bcd, new_hi
  );

  modport slave (
    input  start_btn, hit, game_over,
    output timer_reset, running, state,
    output score_bcd, hi_bcd, new_hi
  );

endinterface

// File: rtl/bcd_inc4.sv
// Combinational 4-digit BCD incrementer, saturating at 9999.
module bcd_inc4
  import game_pkg::*;
(
  input  logic [15:0] value,
  output logic [15:0] result
);

  bcd_digit_t d;
  logic       carry;

  always_comb begin
    result = value;
    carry  = 1'b1;
    d      = '0;
    if (value != SCORE_MAX_BCD) begin
      for (int i = 0; i < 4; i++) begin
        d = value[i*4 +: 4];
        if (carry) begin
          if (d == 4'd9) begin
            result[i*4 +: 4] = 4'd0;
          end else begin
            result[i*4 +: 4] = d + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: start debounce, IDLE/ARM/RUN/OVER FSM, BCD score.
// Define GAME_CTRL_HISCORE_EN to build the high-score register.
module game_ctrl
  import game_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ARM_CYCLES      = 4
) (
  input  logic      clock,
  input  logic      reset,
  game_ctrl_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW = $clog2(ARM_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0]          db_cnt;
  logic                   db_q;
  logic                   db_d1;
  logic                   synced;
  logic                   start_pulse;

  assign synced      = sync_q[SYNC_STAGES-1];
  assign start_pulse = db_q & ~db_d1;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      db_cnt <= '0;
      db_q   <= 1'b0;
      db_d1  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.start_btn};
      db_d1  <= db_q;
      if (synced == db_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt <= '0;
        db_q   <= synced;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  game_state_t   state;
  game_state_t   state_n;
  logic [AW-1:0] arm_cnt;
  logic          arm_entry;
  logic [15:0]   score;
  logic [15:0]   score_inc;
  logic          timer_reset_q;
  logic          running_q;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start_pulse) state_n = ARM;
      ARM:  if (arm_cnt == AW'(ARM_CYCLES - 1)) state_n = RUN;
      RUN:  if (bus.game_over) state_n = OVER;
      OVER: if (start_pulse) state_n = ARM;
      default: state_n = IDLE;
    endcase
  end

  assign arm_entry = (state_n == ARM) && (state != ARM);

  bcd_inc4 u_inc (
    .value  (score),
    .result (score_inc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      arm_cnt       <= '0;
      score         <= '0;
      timer_reset_q <= 1'b1;
      running_q     <= 1'b0;
    end else begin
      state         <= state_n;
      arm_cnt       <= (state == ARM) ? arm_cnt + AW'(1) : '0;
      timer_reset_q <= (state == IDLE) || (state == ARM);
      running_q     <= (state == RUN);
      if (arm_entry)
        score <= '0;
      else if (state == RUN && bus.hit)
        score <= score_inc;
    end
  end

`ifdef GAME_CTRL_HISCORE_EN
  logic [15:0] hi_q;
  logic        new_hi_q;
  logic        over_first;

  // BCD digits order the same way as plain binary
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q       <= '0;
      new_hi_q   <= 1'b0;
      over_first <= 1'b0;
    end else begin
      over_first <= (state == RUN) && (state_n == OVER);
      if (arm_entry) begin
        new_hi_q <= 1'b0;
      end else if (over_first && state == OVER && score > hi_q) begin
        hi_q     <= score;
        new_hi_q <= 1'b1;
      end
    end
  end

  assign bus.hi_bcd = hi_q;
  assign bus.new_hi = new_hi_q;
`else
  assign bus.hi_bcd = '0;
  assign bus.new_hi = 1'b0;
`endif

  assign bus.state       = state;
  assign bus.score_bcd   = score;
  assign bus.timer_reset = timer_reset_q;
  assign bus.running     = running_q;

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Game-flow controller that sits downstream of the countdown timer and consumes its game_over level.
- Also drives the timer's reset input, so it controls when a new countdown starts.
- Debounces the start button, runs an IDLE/ARM/RUN/OVER state machine, and keeps a 4-digit BCD score with an optional high score for the display mux.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on start_btn (minimum 2)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a new start_btn level (1 ms at 50 MHz)
ARM_CYCLES, 4, number of cycles timer_reset stays high in ARM before RUN starts (minimum 1)

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
start_btn  in  1  raw asynchronous push-button, high = pressed
hit  in  1  single-cycle scoring pulse, synchronous to clock
game_over  in  1  level from the countdown timer; high = time expired
timer_reset  out  1  registered; drives the timer's reset input
running  out  1  registered; high while state is RUN
state  out  2  current state: 0 IDLE, 1 ARM, 2 RUN, 3 OVER
score_bcd  out  16  four BCD digits, [3:0] = units
hi_bcd  out  16  high score as four BCD digits, [3:0] = units
new_hi  out  1  high while the last game set a new high score

Behaviour:
- Clock and reset: single clock domain. reset is synchronous and active-high.
- Reset values: state=IDLE, timer_reset=1, running=0, score_bcd=0, hi_bcd=0, new_hi=0. Synchroniser, debounce counter and debounced level are all 0.
- Debounce:
  - start_btn passes through SYNC_STAGES flops.
  - A counter runs while the synchronised value differs from the debounced level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronised value.
  - A rising edge of the debounced level produces start_pulse, one cycle wide.
  - Latency from a stable press to start_pulse: SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- State machine (next-state logic is combinational; all outputs are registered):
  - IDLE: timer_reset=1. On start_pulse, go to ARM and clear score to 0.
  - ARM: timer_reset=1. An arm counter counts ARM_CYCLES cycles, then go to RUN. hit and start_pulse are ignored.
  - RUN: timer_reset=0, running=1. Each hit adds 1 to the BCD score with decimal carry across digits. The score saturates at 9999: a hit at 9999 leaves 9999. When game_over=1, go to OVER. A hit in the same cycle as game_over is still counted. start_pulse is ignored.
  - OVER: running=0, timer_reset=0 (the timer holds its expired display). Score is frozen and hits are ignored. On start_pulse, go to ARM, clear score to 0 and clear new_hi.
- High-score update (OVER only):
  - Evaluated in the first cycle after entering OVER.
  - If score_bcd > hi_bcd (compared as BCD, which orders correctly as binary), hi_bcd takes score_bcd and new_hi is set.
  - An equal score does not set new_hi.
  - new_hi holds until the next ARM entry.
- Output timing: timer_reset and running change one cycle after the state changes.
- Reset in any state: everything returns to the reset values on the next edge, including hi_bcd.

Optional Feature:
- Macro: GAME_CTRL_HISCORE_EN.
- Defined: hi_bcd and new_hi behave as described above.
- Undefined: no high-score register and no comparator. hi_bcd is tied to 0 and new_hi is tied to 0. The port list is unchanged.

Decomposition:
- Package game_pkg holds:
  - the 2-bit state enum (IDLE, ARM, RUN, OVER);
  - a bcd_digit_t typedef (4 bits);
  - the constant SCORE_MAX_BCD = 16'h9999.
- One sub-module, bcd_inc4: combinational 4-digit saturating BCD incrementer, with the score register held in game_ctrl.
- The debouncer stays inline.

Test Plan:
- Reset, then idle with start_btn=0 -> state=0, timer_reset=1, running=0, score_bcd=16'h0000.
- Debounce, with DEBOUNCE_CYCLES=8 and SYNC_STAGES=2:
  - a 5-cycle press produces no state change;
  - a 20-cycle press causes ARM entry exactly 11 cycles after the press starts;
  - timer_reset stays 1 for 4 cycles, then running=1.
- Scoring in RUN: 12 hits, one every other cycle, gives score_bcd=16'h0012. Preload via hits to 16'h0099, then one more hit gives 16'h0100.
- Saturation: drive the score to 16'h9999, then 3 more hits -> score stays 16'h9999.
- Game end: hit and game_over in the same cycle gives OVER with the hit counted. Later hits do not change the score. A start press gives ARM with score 16'h0000.
- With GAME_CTRL_HISCORE_EN:
  - game 1 scores 0x0025, so hi_bcd=16'h0025 and new_hi=1;
  - game 2 scores 0x0025 again, so hi_bcd is unchanged and new_hi=0;
  - without the macro, hi_bcd=0 and new_hi=0 throughout.
